// File: rtl/pio_out_pulse_if.sv
// Avalon-MM slave bus bundle for the output PIO.
interface pio_out_pulse_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/pio_out_pulse.sv
// Output PIO with set/clear writes, a one-shot pulse engine, a sticky done register and a maskable level IRQ.
module pio_out_pulse #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      CNT_WIDTH   = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  pio_out_pulse_if.slave   bus,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam int unsigned DW = 32;

  localparam logic [2:0] ADDR_DATA  = 3'd0;
  localparam logic [2:0] ADDR_LEN   = 3'd1;
  localparam logic [2:0] ADDR_PULSE = 3'd2;
  localparam logic [2:0] ADDR_DONE  = 3'd3;
  localparam logic [2:0] ADDR_SET   = 3'd4;
  localparam logic [2:0] ADDR_CLR   = 3'd5;
  localparam logic [2:0] ADDR_MASK  = 3'd6;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic [WIDTH-1:0]     active_q, active_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     done_q, done_d;
  logic [WIDTH-1:0]     mask_q, mask_d;
  logic [DW-1:0]        rdata_q, rdata_d;

  logic                 wr_c;
  logic [WIDTH-1:0]     wd_c;
  logic                 trig_c;
  logic                 unused_wd;

  // Decoded bus write strobe, per-bit write data and pulse trigger.
  assign wr_c      = bus.chipselect & ~bus.write_n;
  assign wd_c      = bus.writedata[WIDTH-1:0];
  assign trig_c    = wr_c && (bus.address == ADDR_PULSE) && (wd_c != '0);
  assign unused_wd = ^bus.writedata;

  // Register writes, pulse trigger and expiry, applied in that order, plus the read mux.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    len_d    = len_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    mask_d   = mask_q;
    rdata_d  = '0;

    case (bus.address)
      ADDR_DATA:  rdata_d = DW'(data_q);
      ADDR_LEN:   rdata_d = DW'(len_q);
      ADDR_PULSE: rdata_d = DW'(active_q);
      ADDR_DONE:  rdata_d = DW'(done_q);
      ADDR_MASK:  rdata_d = DW'(mask_q);
      default:    rdata_d = '0;
    endcase

    if (wr_c) begin
      case (bus.address)
        ADDR_DATA: data_d = wd_c;
        ADDR_LEN:  len_d  = bus.writedata[CNT_WIDTH-1:0];
        ADDR_DONE: done_d = done_q & ~wd_c;
        ADDR_SET:  data_d = data_q | wd_c;
        ADDR_CLR: begin
          data_d   = data_q & ~wd_c;
          active_d = active_q & ~wd_c;
        end
        ADDR_MASK: mask_d = wd_c;
        default: ;
      endcase
    end

    if (trig_c) begin
      // Retrigger restarts the shared count for every active bit.
      active_d = active_d | wd_c;
      data_d   = data_d | wd_c;
      cnt_d    = (len_q == '0) ? CNT_WIDTH'(1) : len_q;
    end else if (state_q == BUSY) begin
      if (cnt_q == CNT_WIDTH'(1)) begin
        // Expiry: set wins over a coincident done clear.
        data_d   = data_d & ~active_d;
        done_d   = done_d | active_d;
        active_d = '0;
      end else begin
        cnt_d = cnt_q - CNT_WIDTH'(1);
      end
    end

    state_d = (active_d != '0) ? BUSY : IDLE;
  end

  // State and register flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      data_q   <= RESET_VALUE;
      len_q    <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      done_q   <= '0;
      mask_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      len_q    <= len_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      mask_q   <= mask_d;
      rdata_q  <= rdata_d;
    end
  end

  assign out_port     = data_q;
  assign irq          = |(done_q & mask_q);
  assign bus.readdata = rdata_q;

endmodule

// File: tb/tb_pio_out_pulse.sv
// Self-checking bench for pio_out_pulse: directed scenarios plus randomized bus traffic against a deadline-based model.
module tb_pio_out_pulse;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] out_port;
  logic       irq;

  pio_out_pulse_if bus ();

  pio_out_pulse #(
    .WIDTH      (8),
    .CNT_WIDTH  (16),
    .RESET_VALUE(8'h5A)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .out_port(out_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model: outputs are tracked as register values; the pulse is an absolute expiry edge number.
  logic [7:0]  m_data;
  logic [15:0] m_len;
  logic [7:0]  m_active;
  logic [7:0]  m_done;
  logic [7:0]  m_mask;
  logic [31:0] m_rd;
  int          m_deadline;
  int          cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    logic       wr;
    logic [7:0] wd;
    int         n;
    cyc++;
    if (reset) begin
      m_data = 8'h5A; m_len = '0; m_active = '0; m_done = '0; m_mask = '0; m_rd = '0;
      m_deadline = 0;
      return;
    end
    case (bus.address)
      3'd0: m_rd = {24'h0, m_data};
      3'd1: m_rd = {16'h0, m_len};
      3'd2: m_rd = {24'h0, m_active};
      3'd3: m_rd = {24'h0, m_done};
      3'd6: m_rd = {24'h0, m_mask};
      default: m_rd = 32'h0;
    endcase
    wr = bus.chipselect && !bus.write_n;
    wd = bus.writedata[7:0];
    if (wr) begin
      case (bus.address)
        3'd0: m_data = wd;
        3'd1: m_len = bus.writedata[15:0];
        3'd3: m_done = m_done & ~wd;
        3'd4: m_data = m_data | wd;
        3'd5: begin m_data = m_data & ~wd; m_active = m_active & ~wd; end
        3'd6: m_mask = wd;
        default: ;
      endcase
    end
    if (wr && bus.address == 3'd2 && wd != 8'h0) begin
      n = (m_len == 16'h0) ? 1 : int'(m_len);
      m_active = m_active | wd;
      m_data = m_data | wd;
      m_deadline = cyc + n;
    end else if (m_active != 8'h0 && cyc == m_deadline) begin
      m_data = m_data & ~m_active;
      m_done = m_done | m_active;
      m_active = 8'h0;
    end
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_port", {24'h0, out_port}, {24'h0, m_data});
      check("irq", {31'h0, irq}, {31'h0, |(m_done & m_mask)});
      check("readdata", bus.readdata, m_rd);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
    tick();
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'h0;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [31:0] v);
    bus.address = a;
    tick();
    v = bus.readdata;
  endtask

  logic [31:0] v;
  int hi0, hi1;

  initial begin
    reset = 1'b1;
    bus.address = 3'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'h0;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;

    // Reset state and first read latency.
    check("reset out_port", {24'h0, out_port}, 32'h5A);
    check("reset irq", {31'h0, irq}, 32'h0);
    rd_reg(3'd0, v);
    check("reset read data", v, 32'h0000005A);
    check("model reset data", {24'h0, m_data}, 32'h5A);

    // Set / clear writes.
    wr_reg(3'd0, 32'h0);
    wr_reg(3'd4, 32'hFFFF_FF81);
    check("outset", {24'h0, out_port}, 32'h81);
    wr_reg(3'd5, 32'h01);
    check("outclear", {24'h0, out_port}, 32'h80);
    rd_reg(3'd4, v);
    check("read outset addr", v, 32'h0);
    wr_reg(3'd0, 32'h0);

    // Five-cycle pulse with IRQ.
    wr_reg(3'd1, 32'd5);
    wr_reg(3'd6, 32'h04);
    wr_reg(3'd2, 32'h04);
    hi0 = int'(out_port[2]);
    repeat (8) begin tick(); hi0 += int'(out_port[2]); end
    check("pulse5 width", hi0, 32'd5);
    rd_reg(3'd3, v);
    check("pulse5 done", v, 32'h04);
    check("pulse5 irq", {31'h0, irq}, 32'h1);
    check("model pulse5 done", {24'h0, m_done}, 32'h04);
    wr_reg(3'd3, 32'h04);
    check("done clear irq", {31'h0, irq}, 32'h0);

    // Zero length gives a single-cycle pulse.
    wr_reg(3'd1, 32'd0);
    wr_reg(3'd2, 32'h01);
    hi0 = int'(out_port[0]);
    repeat (4) begin tick(); hi0 += int'(out_port[0]); end
    check("pulse0 width", hi0, 32'd1);

    // Retrigger at cycle 4 with length 10: both bits end together.
    wr_reg(3'd3, 32'hFF);
    wr_reg(3'd1, 32'd10);
    wr_reg(3'd2, 32'h01);
    hi0 = int'(out_port[0]); hi1 = int'(out_port[1]);
    repeat (3) begin tick(); hi0 += int'(out_port[0]); hi1 += int'(out_port[1]); end
    wr_reg(3'd2, 32'h02);
    hi0 += int'(out_port[0]); hi1 += int'(out_port[1]);
    repeat (20) begin tick(); hi0 += int'(out_port[0]); hi1 += int'(out_port[1]); end
    check("retrigger bit0 width", hi0, 32'd14);
    check("retrigger bit1 width", hi1, 32'd10);
    rd_reg(3'd3, v);
    check("retrigger done", v, 32'h03);

    // OUTCLEAR aborts the pulse without done.
    wr_reg(3'd3, 32'hFF);
    wr_reg(3'd1, 32'd8);
    wr_reg(3'd2, 32'h10);
    hi0 = int'(out_port[4]);
    repeat (2) begin tick(); hi0 += int'(out_port[4]); end
    wr_reg(3'd5, 32'h10);
    hi0 += int'(out_port[4]);
    repeat (10) begin tick(); hi0 += int'(out_port[4]); end
    check("outclear abort width", hi0, 32'd3);
    rd_reg(3'd2, v);
    check("outclear active", v, 32'h0);
    rd_reg(3'd3, v);
    check("outclear done", v, 32'h0);

    // Expiry coincident with a DONE clear of all bits.
    wr_reg(3'd1, 32'd1);
    wr_reg(3'd2, 32'h01);
    tick();
    wr_reg(3'd1, 32'd3);
    wr_reg(3'd2, 32'h20);
    tick();
    tick();
    wr_reg(3'd3, 32'hFF);
    rd_reg(3'd3, v);
    check("coincident done", v, 32'h20);

    // Reset mid-pulse restores every register.
    wr_reg(3'd6, 32'hFF);
    wr_reg(3'd1, 32'd8);
    wr_reg(3'd2, 32'h08);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset out_port", {24'h0, out_port}, 32'h5A);
    rd_reg(3'd2, v);
    check("midreset active", v, 32'h0);
    rd_reg(3'd1, v);
    check("midreset len", v, 32'h0);
    rd_reg(3'd6, v);
    check("midreset mask", v, 32'h0);
    repeat (10) tick();
    rd_reg(3'd3, v);
    check("midreset done", v, 32'h0);

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      bus.chipselect = ($urandom_range(0, 3) != 0);
      bus.write_n = 1'($urandom_range(0, 1));
      bus.address = 3'($urandom_range(0, 7));
      bus.writedata = $urandom;
      if (bus.address == 3'd1)
        bus.writedata = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 9));
      else if (bus.address == 3'd2 && $urandom_range(0, 1) == 1)
        bus.writedata = ($urandom & 32'hFFFF_FF00) | (32'h1 << $urandom_range(0, 7));
      tick();
    end
    reset = 1'b0; bus.chipselect = 1'b0; bus.write_n = 1'b1;
    repeat (3) tick();
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
